// File: rtl/integrator_pkg.sv
// Shared defaults and helpers for the interleaved recirculating integrator.
// Optional carry chain between words is enabled by INTEGRATOR_CARRY_CHAIN_EN.
package integrator_pkg;

  localparam int WORD_LENGTH = 8;
  localparam int LATENCY     = 4;

  // The least-significant word of a multi-word operand never takes a carry in.
  function automatic logic select_carry(input logic carry, input logic lsb_word);
    return lsb_word ? 1'b0 : carry;
  endfunction

endpackage

// File: rtl/integrator_seq_delay_line.sv
// Recirculating shift register of depth words; word 0 is the newest, the
// oldest word (depth-1) is presented on data_out straight from its flop.
module integrator_seq_delay_line #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [width-1:0] data_in,
  output logic [width-1:0] data_out
);

  logic [width-1:0] words [depth];

  // NOTE: every word is a plain register that must read 0 after reset, so the
  // whole array is cleared; this prevents inference of a RAM macro.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) words[i] <= '0;
    end else if (enable) begin
      // NOTE: non-blocking assignments make each word take its neighbour's
      // pre-edge value, giving a true shift instead of a ripple-through.
      words[0] <= data_in;
      for (int i = 1; i < depth; i++) words[i] <= words[i-1];
    end
  end

  assign data_out = words[depth-1];

endmodule

// File: rtl/integrator_seq.sv
// Interleaved integrator: latency accumulator words share one adder and
// recirculate; optional inter-word carry chain under INTEGRATOR_CARRY_CHAIN_EN.
module integrator_seq
  import integrator_pkg::*;
#(
  parameter int word_length = WORD_LENGTH,
  parameter int latency     = LATENCY
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [word_length-1:0] data_in,
  input  logic                   hold,
  input  logic                   LSB_flag,
  output logic [word_length-1:0] data_out
);

  logic [word_length:0] pre_sum;
  logic                 carry_in;

`ifdef INTEGRATOR_CARRY_CHAIN_EN
  logic carry_q;

  assign carry_in = select_carry(carry_q, LSB_flag);

  // The carry pairs with the word just written, so it advances only with the shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else if (!hold) begin
      carry_q <= pre_sum[word_length];
    end
  end
`else
  assign carry_in = 1'b0;

  logic unused_carry;
  assign unused_carry = &{1'b0, LSB_flag, pre_sum[word_length]};
`endif

  assign pre_sum = {1'b0, data_in} + {1'b0, data_out}
                 + {{word_length{1'b0}}, carry_in};

  integrator_seq_delay_line #(
    .width (word_length),
    .depth (latency)
  ) u_delay_line (
    .clock    (clock),
    .reset    (reset),
    .enable   (!hold),
    .data_in  (pre_sum[word_length-1:0]),
    .data_out (data_out)
  );

endmodule

// File: tb/tb_integrator_seq.sv
// Self-checking bench for integrator_seq: a latency-4 and a latency-1 instance
// share stimulus and are compared each cycle against a slot-based model.
module tb_integrator_seq;
  import integrator_pkg::*;

  localparam int W = WORD_LENGTH;
  localparam int L = LATENCY;
`ifdef INTEGRATOR_CARRY_CHAIN_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         hold;
  logic         LSB_flag;
  logic [W-1:0] data_in;
  logic [W-1:0] out4;
  logic [W-1:0] out1;

  always #5 clock = ~clock;

  integrator_seq #(.word_length(W), .latency(L)) dut4 (
    .clock(clock), .reset(reset), .data_in(data_in),
    .hold(hold), .LSB_flag(LSB_flag), .data_out(out4)
  );

  integrator_seq #(.word_length(W), .latency(1)) dut1 (
    .clock(clock), .reset(reset), .data_in(data_in),
    .hold(hold), .LSB_flag(LSB_flag), .data_out(out1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: L independent accumulator slots visited round-robin; the
  // slot due next is the one visible on data_out.
  int acc4 [L];
  int ptr4;
  int carry4;
  int acc1;
  int carry1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int s;
    int mod;
    mod = 1 << W;
    if (reset) begin
      for (int i = 0; i < L; i++) acc4[i] = 0;
      ptr4 = 0; carry4 = 0; acc1 = 0; carry1 = 0;
    end else if (!hold) begin
      s = int'(data_in) + acc4[ptr4] + ((CARRY_EN && !LSB_flag) ? carry4 : 0);
      acc4[ptr4] = s % mod;
      carry4 = s / mod;
      ptr4 = (ptr4 + 1) % L;
      s = int'(data_in) + acc1 + ((CARRY_EN && !LSB_flag) ? carry1 : 0);
      acc1 = s % mod;
      carry1 = s / mod;
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic lsb, input logic [W-1:0] d);
    reset = r; hold = h; LSB_flag = lsb; data_in = d;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    check({tag, "/lat4"}, out4, W'(acc4[ptr4]));
    check({tag, "/lat1"}, out1, W'(acc1));
  endtask

  // data_out after edges 4..12 of the 1..9 ramp (then zeros): sums seen L-1 edges late.
  int exp_ramp [9] = '{1, 2, 3, 4, 6, 8, 10, 12, 15};

  task automatic ramp(input string tag);
    for (int k = 1; k <= 12; k++) begin
      drive(1'b0, 1'b0, 1'b1, (k <= 9) ? W'(k) : '0);
      step(tag);
      if (k >= 4) check($sformatf("%s_edge%0d", tag, k), out4, W'(exp_ramp[k-4]));
    end
  endtask

  initial begin
    logic [W-1:0] frozen;

    // Reset with hold=1 and arbitrary data.
    drive(1'b1, 1'b1, 1'b0, 8'hA5);
    step("reset");
    check("reset_zero", out4, '0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, $urandom_range(0, 1), W'($urandom));
      step("hold_after_reset");
      check("hold_after_reset_zero", out4, '0);
    end

    // Recirculating accumulation ramp.
    ramp("ramp");

    // Hold freeze mid-sequence, then resume.
    drive(1'b0, 1'b0, 1'b1, 8'h11);
    step("pre_hold");
    frozen = out4;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, W'($urandom));
      step("hold");
      check("hold_frozen", out4, frozen);
    end
    for (int i = 0; i < 2 * L; i++) begin
      drive(1'b0, 1'b0, 1'b1, W'($urandom));
      step("resume");
    end

    // Reset mid-run with hold asserted takes priority, then replay the ramp.
    drive(1'b1, 1'b1, 1'b1, 8'h3C);
    step("reset_mid");
    check("reset_mid_zero", out4, '0);
    ramp("replay");

    // Wrap and carry on the single-word instance.
    drive(1'b1, 1'b0, 1'b1, '0);
    step("wrap_reset");
    drive(1'b0, 1'b0, 1'b1, 8'h01);
    step("wrap_seed");
    check("wrap_seed_value", out1, 8'h01);
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    step("wrap_overflow");
    check("wrap_overflow_value", out1, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step("wrap_carry");
    check("wrap_carry_value", out1, CARRY_EN ? 8'h01 : 8'h00);

    // Randomized traffic with occasional holds and resets.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 1), W'($urandom));
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
